// File: rtl/id_pkg.sv
// Shared types and constants for the ID-stage RAW scoreboard.
package id_pkg;

    localparam int REG_NUM = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_entry_t;

    // U-type and JAL carry immediate bits where rs1 would sit.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one source register against every tracked in-flight destination.
module sb_match
    import id_pkg::*;
#(
    parameter int NUM_STAGES = 3
) (
    input  sb_entry_t [NUM_STAGES-1:0] entries,
    input  logic      [4:0]            src,
    output logic                       hit
);

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (entries[k].vld && (entries[k].rd == src)) begin
                hit = 1'b1;
            end
        end
        if (src == 5'd0) begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// RAW hazard scoreboard for the non-forwarding 5-stage pipeline (ID stage).
// Optional macro SCOREBOARD_RF_WRFIRST_EN: write-first RF, WB entry not counted.
module id_scoreboard
    import id_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_instr,
    input  logic               i_insn_vld,
    input  logic               i_rd_wren,
    input  logic               i_is_rs2,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_bubble,
    output logic [REG_NUM-1:0] o_pending,
    output logic [CNT_W-1:0]   o_stall_cnt
);

    sb_entry_t [NUM_STAGES-1:0] entry;
    sb_entry_t [NUM_STAGES-1:0] visible;
    sb_entry_t                  new_entry;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       hazard;
    logic       issue;
    logic       unused_instr_bits;

    assign opcode            = i_instr[6:0];
    assign rd                = i_instr[11:7];
    assign rs1               = i_instr[19:15];
    assign rs2               = i_instr[24:20];
    assign unused_instr_bits = ^{i_instr[31:25], i_instr[14:12]};

    always_comb begin
        visible = entry;
`ifdef SCOREBOARD_RF_WRFIRST_EN
        visible[NUM_STAGES-1].vld = 1'b0;
`else
`endif
    end

    sb_match #(.NUM_STAGES(NUM_STAGES)) u_match_rs1 (
        .entries (visible),
        .src     (rs1),
        .hit     (rs1_hit)
    );

    sb_match #(.NUM_STAGES(NUM_STAGES)) u_match_rs2 (
        .entries (visible),
        .src     (rs2),
        .hit     (rs2_hit)
    );

    // A flush kills the ID instruction, so it overrides any hazard.
    assign hazard   = i_insn_vld && ((uses_rs1(opcode) && rs1_hit) || (i_is_rs2 && rs2_hit));
    assign o_stall  = hazard && !i_flush;
    assign o_bubble = o_stall || i_flush;
    assign issue    = i_insn_vld && !o_stall && !i_flush;

    always_comb begin
        new_entry.vld = issue && i_rd_wren && (rd != 5'd0);
        new_entry.rd  = rd;
    end

    always_comb begin
        o_pending = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (visible[k].vld) begin
                o_pending[visible[k].rd] = 1'b1;
            end
        end
        o_pending[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            entry <= '0;
        end else begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                entry[k] <= entry[k-1];
            end
            entry[0] <= new_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (o_stall && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard (CNT_W=4 to reach saturation quickly).
module tb_id_scoreboard;
    import id_pkg::*;

`ifdef SCOREBOARD_RF_WRFIRST_EN
    localparam int EXP_STALL = 2;
`else
    localparam int EXP_STALL = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        insn_vld = 1'b0;
    logic        rd_wren = 1'b0;
    logic        is_rs2 = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        bubble;
    logic [31:0] pending;
    logic [3:0]  stall_cnt;

    int n_checks = 0;
    int n_fail = 0;

    id_scoreboard #(.NUM_STAGES(3), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_instr     (instr),
        .i_insn_vld  (insn_vld),
        .i_rd_wren   (rd_wren),
        .i_is_rs2    (is_rs2),
        .i_flush     (flush),
        .o_stall     (stall),
        .o_bubble    (bubble),
        .o_pending   (pending),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd_n, input int rs1_n, input int rs2_n);
        return {7'b0, rs2_n[4:0], rs1_n[4:0], 3'b0, rd_n[4:0], op};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic vld, input logic wren,
                         input logic rs2u, input logic fl);
        instr    = ins;
        insn_vld = vld;
        rd_wren  = wren;
        is_rs2   = rs2u;
        flush    = fl;
    endtask

    task automatic idle();
        drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        advance();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #3;
        n_checks++;
        if (pending !== 32'd0 || stall !== 1'b0 || bubble !== 1'b0 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: pending=%h stall=%b bubble=%b cnt=%0d, want 0/0/0/0",
                     pending, stall, bubble, stall_cnt);
        end
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_reset();
        drive(enc(OP_IMM, 5, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_producer_stall: stall=%b want 0", stall);
        end
        advance();
        drive(enc(OP_REG, 6, 5, 5), 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || pending !== 32'h20) begin
            n_fail++;
            $display("[TB] FAIL b2b_first_stall: stall=%b bubble=%b pending=%h want 1/1/00000020",
                     stall, bubble, pending);
        end
        cycles = 0;
        while (stall === 1'b1 && cycles < 10) begin
            cycles++;
            advance();
            sample();
        end
        n_checks++;
        if (cycles != EXP_STALL) begin
            n_fail++;
            $display("[TB] FAIL b2b_stall_len: got %0d cycles want %0d", cycles, EXP_STALL);
        end
        n_checks++;
        if (bubble !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_issue_bubble: bubble=%b want 0", bubble);
        end
        advance();
        idle();
        sample();
        n_checks++;
        if (stall_cnt !== 4'(EXP_STALL) || pending !== 32'h40) begin
            n_fail++;
            $display("[TB] FAIL b2b_after_issue: cnt=%0d pending=%h want %0d/00000040",
                     stall_cnt, pending, EXP_STALL);
        end
    endtask

    task automatic test_x0_and_unused();
        do_reset();
        drive(enc(OP_IMM, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(enc(OP_REG, 1, 0, 0), 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b0 || pending !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL x0_no_stall: stall=%b pending=%h want 0/0", stall, pending);
        end
        advance();
        drive(enc(OP_LUI, 7, 7, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(enc(OP_LUI, 7, 7, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b0 || pending !== 32'h82) begin
            n_fail++;
            $display("[TB] FAIL lui_rs1_unused: stall=%b pending=%h want 0/00000082", stall, pending);
        end
        advance();
        drive(enc(OP_STORE, 0, 0, 7), 1'b1, 1'b0, 1'b1, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL sw_rs2_hazard: stall=%b want 1", stall);
        end
        advance();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        drive(enc(OP_JAL, 1, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(enc(OP_REG, 2, 1, 1), 1'b1, 1'b1, 1'b1, 1'b1);
        sample();
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_priority: stall=%b bubble=%b want 0/1", stall, bubble);
        end
        advance();
        drive(enc(OP_REG, 3, 1, 0), 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b1 || pending !== 32'h2) begin
            n_fail++;
            $display("[TB] FAIL flush_jal_tracked: stall=%b pending=%h want 1/00000002", stall, pending);
        end
        advance();
        idle();
    endtask

    task automatic test_invalid();
        do_reset();
        drive(enc(OP_IMM, 5, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(enc(OP_REG, 6, 5, 5), 1'b0, 1'b1, 1'b1, 1'b0);
        sample();
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL invalid_no_stall: stall=%b bubble=%b want 0/0", stall, bubble);
        end
        advance();
        drive(enc(OP_REG, 8, 6, 6), 1'b1, 1'b1, 1'b1, 1'b0);
        sample();
        n_checks++;
        if (pending !== 32'h20 || stall !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL invalid_no_entry: pending=%h stall=%b want 00000020/0", pending, stall);
        end
        advance();
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(enc(OP_IMM, 5, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(enc(OP_REG, 6, 5, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        sample();
        n_checks++;
        if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL areset_pre: stall=%b cnt=%0d want 1/1", stall, stall_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pending !== 32'd0 || stall !== 1'b0 || bubble !== 1'b0 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL areset_mid: pending=%h stall=%b bubble=%b cnt=%0d want 0/0/0/0",
                     pending, stall, bubble, stall_cnt);
        end
        rst_n = 1'b1;
        advance();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(enc(OP_IMM, 5, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(enc(OP_REG, 5, 5, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4 * (EXP_STALL + 1)) advance();
        sample();
        n_checks++;
        if (stall_cnt !== 4'(4 * EXP_STALL)) begin
            n_fail++;
            $display("[TB] FAIL sat_midway: cnt=%0d want %0d", stall_cnt, 4 * EXP_STALL);
        end
        repeat (6 * (EXP_STALL + 1)) advance();
        sample();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: cnt=%0d want 15", stall_cnt);
        end
        advance();
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_x0_and_unused();
        test_flush();
        test_invalid();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- RAW hazard detector for the non-forwarding 5-stage pipeline. Sits in ID beside the decoder.
- Consumes the ID instruction word plus the decoder's insn-valid, rd-write-enable and rs2-used flags.
- Tracks the destination registers of in-flight instructions in EX/MEM/WB with a shift pipeline.
- Produces the stall/bubble controls for the IF/ID register, the PC and the ID/EX register.

Parameters:
- NUM_STAGES, 3, number of tracked in-flight stages after ID (EX, MEM, WB); legal range 1..6.
- CNT_W, 32, width of the stall performance counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_instr  in  32  instruction currently in ID. rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
- i_insn_vld  in  1  decoder says the instruction is a legal instruction.
- i_rd_wren  in  1  decoder register-write enable.
- i_is_rs2  in  1  decoder says rs2 is read.
- i_flush  in  1  taken branch/jump resolved in EX this cycle; kills the instruction in ID.
- o_stall  out  1  hold PC and IF/ID register.
- o_bubble  out  1  load a NOP into the ID/EX register.
- o_pending  out  32  bit r set when some tracked stage holds a write to xr; bit 0 is always 0.
- o_stall_cnt  out  CNT_W  number of cycles with o_stall=1; saturating.

Behaviour:
- Tracking state: entry[k], k=0..NUM_STAGES-1, each {vld, rd[4:0]}. Entry 0 is EX; entry NUM_STAGES-1 is WB.
- Derived signals:
  - rs1_used = opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
  - rs2_used = i_is_rs2.
  - pending(r) = OR over k of (entry[k].vld && entry[k].rd==r), forced 0 for r==0.
- Stall is purely combinational from state and inputs:
  - hazard = i_insn_vld && ((rs1_used && pending(rs1)) || (rs2_used && pending(rs2))).
  - o_stall = hazard && !i_flush.
- o_bubble = o_stall || i_flush.
- Issue:
  - issue = i_insn_vld && !o_stall && !i_flush.
  - Issue alone does not set vld. New entry[0].vld = issue && i_rd_wren && rd!=0; new entry[0].rd = rd.
- Every rising edge, entries shift unconditionally: entry[k] <= entry[k-1]; entry[0] <= new entry. The WB entry drops out after its write cycle.
- Stall wait: a stall lasts until the producer leaves WB, so at most NUM_STAGES cycles.
- Invalid instruction (i_insn_vld=0): no stall, and no entry is issued (bubble entry, vld=0).
- Flush: the ID instruction is discarded as a bubble. Older entries keep shifting, so a JAL in EX keeps its rd tracked.
- Simultaneous flush and hazard: flush wins; o_stall=0, o_bubble=1.
- Duplicate rd in several entries is legal. In-order shift retires them oldest-first, so no WAW check is needed.
- o_pending is a combinational OR over the entries.
- o_stall_cnt increments on each cycle with o_stall=1 and holds at all-ones.
- Reset (async, any time, including mid-stall):
  - All entry vld and o_stall_cnt clear immediately.
  - o_pending=0.
  - o_stall/o_bubble follow combinationally, i.e. 0 unless i_flush=1.
  - Entry rd fields reset to 0.

Optional Feature:
- Macro SCOREBOARD_RF_WRFIRST_EN.
- Defined: the register file is write-first. The WB entry (k=NUM_STAGES-1) is excluded from pending() and o_pending, which shortens a RAW stall by one cycle.
- Undefined: all NUM_STAGES entries count, as described above.

Decomposition:
- Shared package id_pkg:
  - opcode localparams (LUI, AUIPC, JAL, ...).
  - sb_entry_t struct {logic vld; logic [4:0] rd;}.
  - REG_NUM=32.
- One natural sub-module: sb_match. It compares one 5-bit source register against all entries and returns the hit bit; instantiated twice, for rs1 and rs2.

Test Plan:
- Back-to-back RAW: addi x5,x0,1 then add x6,x5,x5 on consecutive cycles. Expect o_stall=1 for 3 cycles (2 with SCOREBOARD_RF_WRFIRST_EN), then issue; o_stall_cnt=3.
- x0 / unused source:
  - addi x0,x0,1 then add x1,x0,x0 -> no stall.
  - lui x7 then lui x7 -> no stall (rs1 unused).
  - sw with rs2=x7 after lui x7 -> stall.
- Flush priority: hazard present with i_flush=1 -> o_stall=0, o_bubble=1, and no entry issued. JAL x1 already in EX stays tracked: a following read of x1 stalls.
- Invalid instruction: i_insn_vld=0 with rs1 matching a pending reg -> o_stall=0, and the new entry[0].vld=0.
- Async reset mid-stall: assert i_rst_n=0 mid-cycle -> o_pending=0, o_stall=0 and o_stall_cnt=0 immediately, without waiting for a clock edge.
- Counter saturation: CNT_W=4 with 20 forced stall cycles -> o_stall_cnt holds at 15.
